// File: rtl/ysyx_idu_ibuf.sv
// Instruction buffer between IFU and decode: a DEPTH-entry FIFO of {inst, pc, pnpc}
// with registered valid/ready on both sides, redirect flush, and register-field
// pre-extraction from the head entry. No combinational path from upstream to downstream.
module ysyx_idu_ibuf #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned REG_LEN = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_pnpc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_pnpc,
    output logic [REG_LEN-1:0]       out_rs1,
    output logic [REG_LEN-1:0]       out_rs2,
    output logic [REG_LEN-1:0]       out_rd,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 32 + 2 * XLEN;

    logic [EW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;

    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [EW-1:0]   w_head;
    logic [31:0]     w_head_inst;
    logic [XLEN-1:0] w_head_pc;
    logic [XLEN-1:0] w_head_pnpc;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    // Readiness depends only on occupancy, never on out_ready, so a full buffer stalls
    // upstream even when downstream drains in the same cycle.
    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty;
    assign w_push    = in_valid & ~w_full & ~flush;
    assign w_pop     = ~w_empty & out_ready & ~flush;
    assign count     = r_count;

    // Next occupancy: +1 on push, -1 on pop, unchanged on both or neither.
    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage write; contents are left untouched by reset and flush.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr] <= {in_inst, in_pc, in_pnpc};
        end
    end

    // Pointers and occupancy; flush returns to the same empty state as reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    assign w_head = r_mem[r_rptr];

    // Head payload is zeroed while empty so decode sees inst 0 and stale storage never leaks.
    always_comb begin
        w_head_inst = '0;
        w_head_pc   = '0;
        w_head_pnpc = '0;
        if (!w_empty) begin
            w_head_inst = w_head[EW-1 -: 32];
            w_head_pc   = w_head[2*XLEN-1 -: XLEN];
            w_head_pnpc = w_head[XLEN-1:0];
        end
    end

    assign out_inst = w_head_inst;
    assign out_pc   = w_head_pc;
    assign out_pnpc = w_head_pnpc;
    assign out_rs1  = w_head_inst[15 +: REG_LEN];
    assign out_rs2  = w_head_inst[20 +: REG_LEN];
    assign out_rd   = w_head_inst[7 +: REG_LEN];

endmodule

// File: doc/ysyx_idu_ibuf.md
# ysyx_idu_ibuf

Parametrised instruction buffer that sits between the IFU and the decode/issue logic. It replaces the single-entry IDU holding register with a DEPTH-entry FIFO of {inst, pc, pnpc}, using a decoupled valid/ready handshake on both sides. It flushes on a redirect and pre-extracts register fields from the head entry for hazard checking. Both handshakes are fully registered, so there is no combinational path between upstream and downstream.

## Interface
- XLEN, default 32: width of pc/pnpc.
- DEPTH, default 4: number of entries. Must be a power of two and ≥ 2.
- REG_LEN, default 5: register index width (4 for RV32E).
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous redirect; empties buffer at next edge.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  buffer can accept an entry this cycle.
- in_inst  in  32  fetched instruction.
- in_pc  in  XLEN  instruction pc.
- in_pnpc  in  XLEN  predicted next pc.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes head this cycle.
- out_inst  out  32  head instruction; 0 when empty.
- out_pc  out  XLEN  head pc; 0 when empty.
- out_pnpc  out  XLEN  head predicted next pc; 0 when empty.
- out_rs1  out  REG_LEN  out_inst[15 +: REG_LEN]; 0 when empty.
- out_rs2  out  REG_LEN  out_inst[20 +: REG_LEN]; 0 when empty.
- out_rd  out  REG_LEN  out_inst[7 +: REG_LEN]; 0 when empty.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- State:
  - Storage array of DEPTH entries.
  - Read pointer and write pointer, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy counter.
- Control signals:
  - in_ready = (count != DEPTH). It does not depend on out_ready.
  - out_valid = (count != 0).
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready & ~flush.
- Push: write {in_inst, in_pc, in_pnpc} at the write pointer, then increment the write pointer.
- Pop: increment the read pointer.
- Count update: count += push − pop. A simultaneous push and pop leaves count unchanged.
- Full: in_ready=0, even if out_ready=1 in the same cycle. A push while full is never accepted.
- Empty: out_valid=0 and all out_* payload fields are forced to 0, so downstream sees inst 0.
- Flush: at the next edge, count=0 and both pointers=0.
  - A push or pop presented in a flush cycle is discarded.
  - Storage contents need not be cleared.
- Outputs are driven from the entry at the read pointer (registered storage). Field extraction is combinational from that entry.
- Entries leave in order; no entry is lost or duplicated across wrap-around.

## Timing
- Reset (asynchronous, immediate):
  - count=0, pointers=0.
  - out_valid=0, in_ready=1.
  - All out_* payload fields = 0.
- Latency: an entry accepted at edge N is on out_* with out_valid=1 after edge N. There is no same-cycle bypass.
- Throughput: 1 push and 1 pop per cycle, sustained, when 0 < count < DEPTH.
- out_* remain stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation: the buffer empties immediately, asynchronously to clock. Operation resumes on the first edge after deassertion.
- Flush and reset together: reset dominates. The result is the same empty state.

## Test plan
- Reset then single push:
  - Stimulus: in_inst=0x00100093, in_pc=0x80000000, in_pnpc=0x80000004, out_ready=0.
  - Required: after 1 edge, out_valid=1, out_rd=1, out_rs1=0, count=1. Outputs hold while out_ready=0.
- Fill to full:
  - Stimulus: 4 pushes with pc 0x80000000..0x8000000C, out_ready=0.
  - Required: count=4, in_ready=0. A 5th push held on in_valid with out_ready=1 is rejected that cycle and accepted on the next edge. Pop order is the pc sequence.
- Streaming wrap-around:
  - Stimulus: continuous push/pop with out_ready=1 for 20 instructions.
  - Required: count stays at 1 and every pc is emitted exactly once, in order.
- Flush mid-stream:
  - Stimulus: count=3, assert flush together with in_valid=1.
  - Required: next cycle count=0, out_valid=0, out_inst=0. The next push appears 1 cycle later.
- Asynchronous reset:
  - Stimulus: assert reset between edges with count=2.
  - Required: out_valid and count drop to 0 before the next edge. in_ready=1.
- Parameter sweep:
  - Stimulus: DEPTH=2 and DEPTH=8, REG_LEN=4; repeat the full and wrap scenarios.
  - Required: in_ready deasserts at 2 and 8 respectively. With REG_LEN=4, out_rd = inst[10:7].
